mem_pattern_filler: RTL and testbench



---
 rtl/mem_pattern_filler.sv | 155 +++++++++++++++
 tb/tb_mem_pattern_filler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_pattern_filler.sv
// Memory pattern filler: writes a constant, counting or address-derived pattern
// over a wrapping address window of a RAM write port with a write/ready handshake.
module mem_pattern_filler #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic              iabort,
  input  logic [1:0]        imode,
  input  logic [ADDR_W-1:0] ibase,
  input  logic [ADDR_W-1:0] ilen,
  input  logic [DATA_W-1:0] iseed,
  input  logic              iready,
  output logic [ADDR_W-1:0] oaddr,
  output logic [DATA_W-1:0] ocontent,
  output logic              owrite,
  output logic              obusy,
  output logic              odone,
  output logic [ADDR_W:0]   owords
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_DEC   = 2'd2;
  localparam logic [1:0] MODE_ADDR  = 2'd3;

  state_t            state, state_nxt;
  logic [1:0]        mode_q, mode_nxt;
  logic [ADDR_W:0]   len_q, len_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] content_nxt;
  logic              write_nxt, busy_nxt, done_nxt;
  logic [ADDR_W:0]   words_nxt;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W:0]   words_inc;
  logic [DATA_W-1:0] pattern_next;
  logic              last_word;

  // Address-mode data: low DATA_W bits of the address, zero-extended if narrower.
  function automatic logic [DATA_W-1:0] addr_to_data(input logic [ADDR_W-1:0] a);
    logic [ADDR_W+DATA_W-1:0] ext;
    ext = {{DATA_W{1'b0}}, a};
    return ext[DATA_W-1:0];
  endfunction

  assign addr_inc  = oaddr + ADDR_W'(1);
  assign words_inc = owords + (ADDR_W+1)'(1);
  assign last_word = (words_inc == len_q);

  always_comb begin
    pattern_next = ocontent;
    case (mode_q)
      MODE_CONST: pattern_next = ocontent;
      MODE_INC:   pattern_next = ocontent + DATA_W'(1);
      MODE_DEC:   pattern_next = ocontent - DATA_W'(1);
      MODE_ADDR:  pattern_next = addr_to_data(addr_inc);
      default:    pattern_next = ocontent;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode_q;
    len_nxt     = len_q;
    addr_nxt    = oaddr;
    content_nxt = ocontent;
    write_nxt   = owrite;
    busy_nxt    = obusy;
    done_nxt    = odone;
    words_nxt   = owords;

    case (state)
      ST_IDLE, ST_DONE: begin
        write_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = (state == ST_DONE);
        if (istart) begin
          state_nxt   = ST_FILL;
          mode_nxt    = imode;
          // A zero length means the whole address space.
          len_nxt     = (ilen == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, ilen};
          addr_nxt    = ibase;
          content_nxt = (imode == MODE_ADDR) ? addr_to_data(ibase) : iseed;
          words_nxt   = '0;
          write_nxt   = 1'b1;
          busy_nxt    = 1'b1;
          done_nxt    = 1'b0;
        end
      end

      ST_FILL: begin
        if (iready) begin
          words_nxt = words_inc;
        end
        if (iabort) begin
          state_nxt = ST_IDLE;
          write_nxt = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b0;
        end else if (iready) begin
          if (last_word) begin
            state_nxt = ST_DONE;
            write_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt    = addr_inc;
            content_nxt = pattern_next;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        write_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_CONST;
      len_q    <= '0;
      oaddr    <= '0;
      ocontent <= '0;
      owrite   <= 1'b0;
      obusy    <= 1'b0;
      odone    <= 1'b0;
      owords   <= '0;
    end else begin
      state    <= state_nxt;
      mode_q   <= mode_nxt;
      len_q    <= len_nxt;
      oaddr    <= addr_nxt;
      ocontent <= content_nxt;
      owrite   <= write_nxt;
      obusy    <= busy_nxt;
      odone    <= done_nxt;
      owords   <= words_nxt;
    end
  end

endmodule

// File: tb/tb_mem_pattern_filler.sv
// Bench for mem_pattern_filler: an index-based write model checked every cycle,
// plus directed fills with literal expectations.
module tb_mem_pattern_filler;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          iclk = 1'b0;
  logic          irst, istart, iabort, iready;
  logic [1:0]    imode;
  logic [AW-1:0] ibase, ilen;
  logic [DW-1:0] iseed;
  logic [AW-1:0] oaddr;
  logic [DW-1:0] ocontent;
  logic          owrite, obusy, odone;
  logic [AW:0]   owords;

  mem_pattern_filler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .iabort(iabort), .imode(imode),
    .ibase(ibase), .ilen(ilen), .iseed(iseed), .iready(iready),
    .oaddr(oaddr), .ocontent(ocontent), .owrite(owrite), .obusy(obusy),
    .odone(odone), .owords(owords)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int   checks = 0;
  int   failures = 0;
  wr_t  exp_q[$];
  wr_t  log_w[16];
  int   log_n = 0;
  int   acc_n = 0;
  int   words_m = 0;
  logic was_stall = 1'b0;
  logic [AW-1:0] prev_a = '0;
  logic [DW-1:0] prev_d = '0;
  logic acc;
  wr_t  e;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  // Word i of a fill, straight from the pattern definitions.
  function automatic wr_t model_word(logic [1:0] m, logic [AW-1:0] b, logic [DW-1:0] s, int i);
    wr_t w;
    w.a = b + AW'(i);
    case (m)
      2'd0: w.d = s;
      2'd1: w.d = s + DW'(i);
      2'd2: w.d = s - DW'(i);
      default: w.d = w.a[DW-1:0];
    endcase
    return w;
  endfunction

  always @(negedge iclk) begin
    chk("busy_vs_write", {31'd0, obusy}, {31'd0, owrite});
    chk("done_and_busy", {31'd0, odone & obusy}, 32'd0);
    chk("owords", {15'd0, owords}, words_m);
    if (was_stall) begin
      chk("stall_write", {31'd0, owrite}, 32'd1);
      chk("stall_addr", {16'd0, oaddr}, {16'd0, prev_a});
      chk("stall_data", {24'd0, ocontent}, {24'd0, prev_d});
    end
    acc = owrite && iready && !irst;
    if (acc) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {16'd0, oaddr}, {16'd0, e.a});
        chk("write_data", {24'd0, ocontent}, {24'd0, e.d});
      end
      if (log_n < 16) log_w[log_n] = '{a: oaddr, d: ocontent};
      log_n++;
      acc_n++;
    end
    if (irst) begin
      words_m = 0;
    end else if (istart && !obusy) begin
      words_m = 0;
      log_n = 0;
      acc_n = 0;
      exp_q.delete();
      for (int i = 0; i < ((ilen == 0) ? 65536 : int'(ilen)); i++)
        exp_q.push_back(model_word(imode, ibase, iseed, i));
    end else if (acc) begin
      words_m++;
    end
    was_stall = owrite && !iready && !iabort && !irst;
    prev_a = oaddr;
    prev_d = ocontent;
  end

  task automatic cycle();
    @(posedge iclk);
    #2;
  endtask

  task automatic arm(logic [1:0] m, logic [AW-1:0] b, logic [AW-1:0] l, logic [DW-1:0] s);
    imode = m; ibase = b; ilen = l; iseed = s; istart = 1'b1;
  endtask

  initial begin
    automatic logic pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    irst = 1'b1; istart = 1'b0; iabort = 1'b0; iready = 1'b0;
    imode = 2'd0; ibase = '0; ilen = '0; iseed = '0;
    repeat (3) cycle();
    @(negedge iclk);
    chk("rst_addr", {16'd0, oaddr}, 32'd0);
    chk("rst_data", {24'd0, ocontent}, 32'd0);
    chk("rst_flags", {29'd0, owrite, obusy, odone}, 32'd0);
    chk("rst_words", {15'd0, owords}, 32'd0);
    irst = 1'b0;
    cycle();

    // Incrementing fill with wrap of the data value
    arm(2'd1, 16'h0010, 16'd4, 8'hFE); iready = 1'b1;
    cycle(); istart = 1'b0;
    repeat (4) cycle();
    @(negedge iclk);
    chk("t1_done", {31'd0, odone}, 32'd1);
    chk("t1_words", {15'd0, owords}, 32'd4);
    chk("t1_acc", acc_n, 32'd4);
    chk("t1_w0", {8'd0, log_w[0]}, 32'h0010FE);
    chk("t1_w1", {8'd0, log_w[1]}, 32'h0011FF);
    chk("t1_w2", {8'd0, log_w[2]}, 32'h001200);
    chk("t1_w3", {8'd0, log_w[3]}, 32'h001301);

    // Constant fill with stalls; restarts straight from DONE
    arm(2'd0, 16'h0200, 16'd3, 8'hA5); iready = 1'b0;
    cycle(); istart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iready = pat[i];
      cycle();
    end
    @(negedge iclk);
    chk("t2_done", {31'd0, odone}, 32'd1);
    chk("t2_acc", acc_n, 32'd3);
    chk("t2_w2", {8'd0, log_w[2]}, 32'h0202A5);

    // Address mode across the top of the address space
    arm(2'd3, 16'hFFFE, 16'd3, 8'h55); iready = 1'b1;
    cycle(); istart = 1'b0;
    repeat (3) cycle();
    @(negedge iclk);
    chk("t3_done", {31'd0, odone}, 32'd1);
    chk("t3_w0", {8'd0, log_w[0]}, 32'hFFFEFE);
    chk("t3_w1", {8'd0, log_w[1]}, 32'hFFFFFF);
    chk("t3_w2", {8'd0, log_w[2]}, 32'h000000);

    // Full address space, decrementing
    arm(2'd2, 16'h0000, 16'd0, 8'h01); iready = 1'b1;
    cycle(); istart = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge iclk);
      if (odone) break;
    end
    chk("t4_done", {31'd0, odone}, 32'd1);
    chk("t4_words", {15'd0, owords}, 32'h10000);
    chk("t4_acc", acc_n, 32'd65536);
    chk("t4_d0", {24'd0, log_w[0].d}, 32'h01);
    chk("t4_d1", {24'd0, log_w[1].d}, 32'h00);
    chk("t4_d2", {24'd0, log_w[2].d}, 32'hFF);

    // Re-arm from DONE; istart during FILL is ignored
    cycle();
    arm(2'd0, 16'h0100, 16'd1, 8'h33); iready = 1'b0;
    cycle();
    @(negedge iclk);
    chk("t6_done_drop", {30'd0, odone, obusy}, 32'b01);
    ibase = 16'h0200; ilen = 16'd5; imode = 2'd1;
    cycle(); cycle();
    istart = 1'b0; iready = 1'b1;
    cycle();
    @(negedge iclk);
    chk("t6_done", {31'd0, odone}, 32'd1);
    chk("t6_acc", acc_n, 32'd1);
    chk("t6_w0", {8'd0, log_w[0]}, 32'h010033);
    chk("t6_words", {15'd0, owords}, 32'd1);

    // Abort coinciding with the 2nd accept of a 5-word fill
    arm(2'd1, 16'h0300, 16'd5, 8'h10); iready = 1'b1;
    cycle(); istart = 1'b0;
    cycle();
    iabort = 1'b1;
    cycle();
    iabort = 1'b0;
    @(negedge iclk);
    chk("t5_words", {15'd0, owords}, 32'd2);
    chk("t5_flags", {29'd0, owrite, obusy, odone}, 32'd0);
    repeat (3) cycle();
    chk("t5_idle", {29'd0, owrite, obusy, odone}, 32'd0);
    chk("t5_acc", acc_n, 32'd2);

    // Reset in the middle of a fill
    arm(2'd1, 16'h0040, 16'd10, 8'h00); iready = 1'b1;
    cycle(); istart = 1'b0;
    repeat (2) cycle();
    irst = 1'b1;
    cycle();
    @(negedge iclk);
    chk("t7_rst_flags", {29'd0, owrite, obusy, odone}, 32'd0);
    chk("t7_rst_addr", {16'd0, oaddr}, 32'd0);
    chk("t7_rst_data", {24'd0, ocontent}, 32'd0);
    chk("t7_rst_words", {15'd0, owords}, 32'd0);
    irst = 1'b0;
    repeat (5) cycle();
    chk("t7_no_write", {31'd0, owrite}, 32'd0);
    chk("t7_acc", acc_n, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
